// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, writeback request type and reset constants for the RF writeback arbiter
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_IDX_W = $clog2(NREG);
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;
  localparam wb_req_t WB_REQ_RST = '0;
  localparam logic [NREG-1:0] SB_RST = '0;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// rfwb_fifo: circular buffer of MDU writeback requests
//   clk, reset (async, active-low)
//   push/push_data : enqueue (ignored when full unless popping in the same cycle)
//   pop            : dequeue head (ignored when empty)
//   head           : current head entry, full/empty : occupancy flags
module rfwb_fifo
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  wb_req_t mem_q [FIFO_DEPTH];
  wb_req_t mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == DEPTH_C;
  assign empty = cnt_q == '0;
  assign head  = mem_q[rd_ptr_q];
  always_comb begin
    do_pop  = pop & !empty;
    do_push = push & (!full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    // depth is a power of two, so pointers wrap by plain overflow
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: WB_REQ_RST};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the RF write port between pipeline WB and buffered MDU results, with busy scoreboard
//   clk, reset (async, active-low)
//   pipe_wb_en/pipe_rd/pipe_data          : pipeline writeback (highest priority)
//   mdu_issue/mdu_issue_rd                : marks destination busy
//   mdu_wb_valid/rd/data, mdu_wb_ready    : MDU result handshake into the FIFO
//   rf_wb_en/rf_rd/rf_wb_data             : register-file write port
//   rs1/rs2/rd_index -> rs1/rs2/rd_busy   : registered scoreboard queries
//   wb_stall                              : asks hazard unit to free the next WB slot
//   RFWB_BYPASS_EN : when defined, an MDU result in an idle slot with an empty FIFO is written same cycle
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_wb_en,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  input  logic                 mdu_issue,
  input  logic [REG_IDX_W-1:0] mdu_issue_rd,
  input  logic                 mdu_wb_valid,
  input  logic [REG_IDX_W-1:0] mdu_wb_rd,
  input  logic [XLEN-1:0]      mdu_wb_data,
  output logic                 mdu_wb_ready,
  output logic                 rf_wb_en,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wb_data,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  input  logic [REG_IDX_W-1:0] rd_index,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 wb_stall
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  logic [NREG-1:0] sb_q, sb_d, set_mask, clr_mask;
  logic [SW-1:0] starve_q, starve_d;
  logic pipe_take, pop, push, bypass, fifo_full, fifo_empty;
  wb_req_t head, push_req;
  assign push_req = '{rd: mdu_wb_rd, data: mdu_wb_data};
  rfwb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );
  always_comb begin
    pipe_take = pipe_wb_en & (pipe_rd != '0);
    pop = !pipe_take & !fifo_empty;
`ifdef RFWB_BYPASS_EN
    bypass = !pipe_take & fifo_empty & mdu_wb_valid & (mdu_wb_rd != '0);
`else
    bypass = 1'b0;
`endif
    mdu_wb_ready = !fifo_full | pop;
    // rd==0 results are acknowledged but dropped
    push = mdu_wb_valid & mdu_wb_ready & (mdu_wb_rd != '0) & !bypass;
    rf_wb_en = pipe_take | pop | bypass;
    rf_rd = pipe_take ? pipe_rd : pop ? head.rd : bypass ? mdu_wb_rd : '0;
    rf_wb_data = pipe_take ? pipe_data : pop ? head.data : bypass ? mdu_wb_data : '0;
    clr_mask = (pop | bypass) ? NREG'(1) << rf_rd : '0;
    set_mask = (mdu_issue & (mdu_issue_rd != '0)) ? NREG'(1) << mdu_issue_rd : '0;
    // set applied after clear so a same-index collision leaves the bit busy
    sb_d = ((sb_q & ~clr_mask) | set_mask) & ~NREG'(1);
    // with a non-empty FIFO and no pop, the pipeline necessarily owns the port
    starve_d = (fifo_empty | pop) ? '0 : (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
  end
  assign rs1_busy = sb_q[rs1_index];
  assign rs2_busy = sb_q[rs2_index];
  assign rd_busy  = sb_q[rd_index];
  assign wb_stall = starve_q == STARVE_LIM;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q     <= SB_RST;
      starve_q <= '0;
    end else begin
      sb_q     <= sb_d;
      starve_q <= starve_d;
    end
  end
endmodule
